// File: rtl/caravel_boot_pkg.sv
// caravel_boot_pkg: FSM states, flash opcode and register map shared by the boot core
package caravel_boot_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_REC, S_APPLY, S_DONE} state_e;
    localparam logic [7:0]  READ_OP       = 8'h03;
    localparam logic [31:0] ADDR_OUT_LO   = 32'h2600_0000;
    localparam logic [31:0] ADDR_OUT_HI   = 32'h2600_0004;
    localparam logic [31:0] ADDR_OE_LO    = 32'h2600_0008;
    localparam logic [31:0] ADDR_OE_HI    = 32'h2600_000C;
    localparam logic [31:0] ADDR_GPIO     = 32'h2100_0000;
    localparam logic [31:0] TERMINATOR    = 32'hFFFF_FFFF;
    // mprj_io[3] is the housekeeping CSB input and must never be driven
    localparam logic [37:0] MPRJ_OE_MASK  = ~(38'd1 << 3);
endpackage

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: mode-0 SPI READ sequencer; shifts out the command and shifts in 64-bit records
module spi_flash_reader
    import caravel_boot_pkg::*;
#(
    parameter logic [23:0] FLASH_BASE = 24'h000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_i,
    input  logic        rx_i,
    input  logic        stop_i,
    input  logic        flash_io1_i,
    output logic        flash_csb_o,
    output logic        flash_clk_o,
    output logic        flash_io0_o,
    output logic        word_valid_o,
    output logic [63:0] word_o
);
    logic [63:0] sr_q, sr_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        act_q, act_d, tx_q, tx_d, sck_q, sck_d, csb_q, csb_d;
    logic        last;

    assign last         = act_q && cnt_q == 7'd0;
    assign word_valid_o = last;
    assign word_o       = sr_q;
    assign flash_csb_o  = csb_q;
    assign flash_clk_o  = sck_q;
    assign flash_io0_o  = tx_q & sr_q[63];

    // Transmit shifts while SCK falls, receive samples while SCK rises
    always_comb begin
        act_d = act_q && !last;
        cnt_d = act_q ? cnt_q - 7'd1 : cnt_q;
        sck_d = act_q && !sck_q;
        tx_d  = tx_q;
        csb_d = csb_q;
        sr_d  = !act_q ? sr_q
              : tx_q   ? (sck_q ? {sr_q[62:0], 1'b0} : sr_q)
              :          (sck_q ? sr_q : {sr_q[62:0], flash_io1_i});
        if (cmd_i || rx_i) begin
            act_d = 1'b1;
            cnt_d = cmd_i ? 7'd63 : 7'd127;
            sck_d = 1'b0;
            tx_d  = cmd_i;
            csb_d = 1'b0;
        end
        if (cmd_i) sr_d = {READ_OP, FLASH_BASE, 32'h0};
        if (stop_i) begin
            act_d = 1'b0;
            sck_d = 1'b0;
            tx_d  = 1'b0;
            csb_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q  <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
            tx_q  <= 1'b0;
            sck_q <= 1'b0;
            csb_q <= 1'b1;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            act_q <= act_d;
            tx_q  <= tx_d;
            sck_q <= sck_d;
            csb_q <= csb_d;
        end
    end
endmodule

// File: rtl/caravel_boot_core.sv
// caravel_boot_core: boots from SPI flash, applying (addr, data) records to the pad register file
module caravel_boot_core
    import caravel_boot_pkg::*;
#(
    parameter int          MAX_RECORDS = 256,
    parameter logic [23:0] FLASH_BASE  = 24'h000000
) (
    input  logic        clock,
    input  logic        resetb,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1,
    inout  wire  [37:0] mprj_io,
    inout  wire         gpio,
    input  logic        vddio,
    input  logic        vssio,
    input  logic        vdda,
    input  logic        vssa,
    input  logic        vccd,
    input  logic        vssd,
    input  logic        vdda1,
    input  logic        vdda2,
    input  logic        vssa1,
    input  logic        vssa2,
    input  logic        vccd1,
    input  logic        vccd2,
    input  logic        vssd1,
    input  logic        vssd2
);
    localparam int CW = $clog2(MAX_RECORDS + 1);

    state_e        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [37:0]   out_q, out_d, oe_q, oe_d;
    logic          gout_q, gout_d, goe_q, goe_d;
    logic          cmd, rx, stop, wv, wr, last_rec;
    logic [63:0]   word;
    logic [31:0]   addr, data;
    logic          unused_supply;

    assign unused_supply = ^{vddio, vssio, vdda, vssa, vccd, vssd, vdda1, vdda2,
                             vssa1, vssa2, vccd1, vccd2, vssd1, vssd2};

    spi_flash_reader #(.FLASH_BASE(FLASH_BASE)) u_reader (
        .clk_i        (clock),
        .rst_ni       (resetb),
        .cmd_i        (cmd),
        .rx_i         (rx),
        .stop_i       (stop),
        .flash_io1_i  (flash_io1),
        .flash_csb_o  (flash_csb),
        .flash_clk_o  (flash_clk),
        .flash_io0_o  (flash_io0),
        .word_valid_o (wv),
        .word_o       (word)
    );

    assign addr     = word[63:32];
    assign data     = word[31:0];
    assign wr       = st_q == S_APPLY && addr != TERMINATOR;
    assign last_rec = cnt_q == CW'(MAX_RECORDS - 1);

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        oe_d   = oe_q;
        gout_d = gout_q;
        goe_d  = goe_q;
        cmd    = 1'b0;
        rx     = 1'b0;
        stop   = 1'b0;
        case (st_q)
            S_IDLE: begin
                st_d = S_CMD;
                cmd  = 1'b1;
            end
            S_CMD: begin
                st_d = wv ? S_REC : S_CMD;
                rx   = wv;
            end
            S_REC: st_d = wv ? S_APPLY : S_REC;
            S_APPLY: begin
                stop = !wr || last_rec;
                rx   = !stop;
                st_d = stop ? S_DONE : S_REC;
            end
            default: st_d = S_DONE;
        endcase
        // Unmapped addresses fall through every field unchanged but still count
        if (wr) begin
            cnt_d        = cnt_q + CW'(1);
            out_d[31:0]  = addr == ADDR_OUT_LO ? data : out_q[31:0];
            out_d[37:32] = addr == ADDR_OUT_HI ? data[5:0] : out_q[37:32];
            oe_d[31:0]   = addr == ADDR_OE_LO ? data : oe_q[31:0];
            oe_d[37:32]  = addr == ADDR_OE_HI ? data[5:0] : oe_q[37:32];
            oe_d         = oe_d & MPRJ_OE_MASK;
            gout_d       = addr == ADDR_GPIO ? data[0] : gout_q;
            goe_d        = addr == ADDR_GPIO ? data[1] : goe_q;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            st_q   <= S_IDLE;
            cnt_q  <= '0;
            out_q  <= '0;
            oe_q   <= '0;
            gout_q <= 1'b0;
            goe_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            oe_q   <= oe_d;
            gout_q <= gout_d;
            goe_q  <= goe_d;
        end
    end

    for (genvar i = 0; i < 38; i++) begin : g_pad
        assign mprj_io[i] = oe_q[i] ? out_q[i] : 1'bz;
    end
    assign gpio = goe_q ? gout_q : 1'bz;
endmodule

// File: tb/tb_caravel_boot_core.sv
// tb_caravel_boot_core: flash-image driven bench with a record-level model of the boot sequence
module tb_caravel_boot_core;
    localparam int MAXR    = 256;
    localparam int T_FIRST = 194;
    localparam int T_REC   = 129;

    logic clock = 1'b0;
    logic resetb = 1'b0;
    logic flash_io1 = 1'b0;
    logic flash_csb, flash_clk, flash_io0;
    tri1 [37:0] mprj_io;
    tri0 gpio;

    caravel_boot_core dut (
        .clock(clock), .resetb(resetb),
        .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0), .flash_io1(flash_io1),
        .mprj_io(mprj_io), .gpio(gpio),
        .vddio(1'b1), .vssio(1'b0), .vdda(1'b1), .vssa(1'b0), .vccd(1'b1), .vssd(1'b0),
        .vdda1(1'b1), .vdda2(1'b1), .vssa1(1'b0), .vssa2(1'b0),
        .vccd1(1'b1), .vccd2(1'b1), .vssd1(1'b0), .vssd2(1'b0)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clock or negedge resetb)
        if (!resetb) cyc <= 0;
        else cyc <= cyc + 1;

    logic [7:0]  mem [4096];
    logic [31:0] img_a [300];
    logic [31:0] img_d [300];
    int          img_n = 0;
    int          n_fetch = 0;
    logic [31:0] cmdw = 32'h0300_0000;

    // Flash: capture the 32-bit command, then stream bytes from the addressed location
    int          fbit = 0;
    logic [31:0] fcmd = 32'h0;
    always @(posedge flash_clk or posedge flash_csb)
        if (flash_csb) fbit <= 0;
        else begin
            if (fbit < 32) fcmd <= {fcmd[30:0], flash_io0};
            fbit <= fbit + 1;
        end

    always @(negedge flash_clk) begin
        int k;
        logic [11:0] ba;
        if (!flash_csb && fbit >= 32) begin
            k = fbit - 32;
            ba = 12'(int'(fcmd[23:0]) + k / 8);
            flash_io1 = mem[ba][7 - k % 8];
        end
    end

    logic [37:0] m_out, m_oe;
    logic        m_gout, m_goe;
    int          m_next;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic rec(input int j, input logic [31:0] a, input logic [31:0] d);
        img_a[j] = a;
        img_d[j] = d;
    endtask

    task automatic load(input int n);
        img_n = n;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int j = 0; j < n; j++)
            for (int b = 0; b < 4; b++) begin
                mem[8*j + b]     = img_a[j][31 - 8*b -: 8];
                mem[8*j + 4 + b] = img_d[j][31 - 8*b -: 8];
            end
        n_fetch = MAXR;
        for (int j = 0; j < n; j++)
            if (img_a[j] == 32'hFFFF_FFFF && j + 1 < n_fetch) n_fetch = j + 1;
    endtask

    task automatic apply(input int j);
        logic [31:0] a, d;
        a = j < img_n ? img_a[j] : 32'h0;
        d = j < img_n ? img_d[j] : 32'h0;
        if (a == 32'h2600_0000) m_out[31:0] = d;
        else if (a == 32'h2600_0004) m_out[37:32] = d[5:0];
        else if (a == 32'h2600_0008) m_oe[31:0] = d;
        else if (a == 32'h2600_000C) m_oe[37:32] = d[5:0];
        else if (a == 32'h2100_0000) begin
            m_gout = d[0];
            m_goe  = d[1];
        end
        m_oe[3] = 1'b0;
    endtask

    // One cycle: advance the model to the current cycle count, then compare every output
    task automatic step();
        logic [37:0] ep;
        logic es, ec, em;
        int r, j;
        @(negedge clock);
        if (!resetb) return;
        while (m_next < n_fetch && T_FIRST + T_REC * m_next <= cyc) begin
            apply(m_next);
            m_next++;
        end
        for (int i = 0; i < 38; i++) ep[i] = m_oe[i] ? m_out[i] : 1'b1;
        es = !(cyc >= 1 && cyc < T_FIRST + T_REC * (n_fetch - 1));
        if (cyc >= 1 && cyc <= 64) begin
            ec = cyc % 2 == 0;
            em = cmdw[31 - (cyc - 1) / 2];
        end else begin
            em = 1'b0;
            j  = (cyc - 65) / T_REC;
            r  = (cyc - 65) % T_REC;
            ec = cyc >= 65 && j < n_fetch && r < 128 && r % 2 == 1;
        end
        check("pads", 64'(mprj_io), 64'(ep));
        check("gpio", 64'(gpio), 64'(m_goe ? m_gout : 1'b0));
        check("csb", 64'(flash_csb), 64'(es));
        check("sck", 64'(flash_clk), 64'(ec));
        check("mosi", 64'(flash_io0), 64'(em));
    endtask

    task automatic start();
        @(posedge clock);
        #2 resetb = 1'b0;
        @(posedge clock);
        #2 resetb = 1'b1;
        m_out  = '0;
        m_oe   = '0;
        m_gout = 1'b0;
        m_goe  = 1'b0;
        m_next = 0;
    endtask

    task automatic run_to(input int c);
        for (int i = 0; i < c + 10 && cyc < c; i++) step();
        check("reach_cycle", 64'(cyc), 64'(c));
    endtask

    task automatic image_a();
        rec(0, 32'h2600_0008, 32'hFFFF_0000);
        rec(1, 32'h2600_0000, 32'hAB60_0000);
        rec(2, 32'h2600_0000, 32'hAB6A_0000);
        rec(3, 32'hFFFF_FFFF, 32'h0);
        load(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clock);
        #2;
        check("rst_csb", 64'(flash_csb), 64'd1);
        check("rst_sck", 64'(flash_clk), 64'd0);
        check("rst_mosi", 64'(flash_io0), 64'd0);
        check("rst_pads", 64'(mprj_io), 64'h3F_FFFF_FFFF);
        check("rst_gpio", 64'(gpio), 64'd0);

        image_a();
        start();
        run_to(322);
        check("a_before", 64'(mprj_io[31:16]), 64'h0000);
        run_to(323);
        check("a_first", 64'(mprj_io[31:16]), 64'hAB60);
        run_to(451);
        check("a_hold", 64'(mprj_io[31:16]), 64'hAB60);
        run_to(452);
        check("a_second", 64'(mprj_io[31:16]), 64'hAB6A);
        run_to(580);
        check("a_csb_low", 64'(flash_csb), 64'd0);
        run_to(581);
        check("a_csb_high", 64'(flash_csb), 64'd1);
        run_to(590);
        check("a_cmd", 64'(fcmd), 64'h0300_0000);

        rec(0, 32'h2600_000C, 32'h0000_003F);
        rec(1, 32'h2600_0004, 32'h0000_0015);
        rec(2, 32'h2600_0008, 32'hFFFF_FFFF);
        rec(3, 32'h2600_0000, 32'h0000_0000);
        rec(4, 32'hFFFF_FFFF, 32'h0);
        load(5);
        start();
        run_to(715);
        check("oe_all_pads", 64'(mprj_io), 64'h15_0000_0008);
        check("hk_csb_z", 64'(mprj_io[3]), 64'd1);

        rec(0, 32'h2600_0008, 32'h0000_00FF);
        rec(1, 32'h2600_0000, 32'h0000_00A5);
        rec(2, 32'h3000_0000, 32'h0000_1234);
        rec(3, 32'h2600_0000, 32'h0000_005A);
        rec(4, 32'hFFFF_FFFF, 32'h0);
        load(5);
        start();
        run_to(452);
        check("ignored_write", 64'(mprj_io[7:0]), 64'hAD);
        run_to(715);
        check("after_ignored", 64'(mprj_io[31:0]), 64'hFFFF_FF5A);

        rec(0, 32'h2100_0000, 32'h0000_0003);
        rec(1, 32'h2100_0000, 32'h0000_0001);
        rec(2, 32'hFFFF_FFFF, 32'h0);
        load(3);
        start();
        run_to(193);
        check("gpio_pre", 64'(gpio), 64'd0);
        run_to(194);
        check("gpio_on", 64'(gpio), 64'd1);
        run_to(323);
        check("gpio_z", 64'(gpio), 64'd0);
        run_to(460);

        image_a();
        start();
        run_to(250);
        #2 resetb = 1'b0;
        #1;
        check("mid_rst_pads", 64'(mprj_io), 64'h3F_FFFF_FFFF);
        check("mid_rst_csb", 64'(flash_csb), 64'd1);
        check("mid_rst_sck", 64'(flash_clk), 64'd0);
        start();
        run_to(323);
        check("replay_first", 64'(mprj_io[31:16]), 64'hAB60);
        run_to(590);
        check("replay_cmd", 64'(fcmd), 64'h0300_0000);

        rec(0, 32'h2600_0008, 32'hFFFF_FFFF);
        for (int j = 1; j < 300; j++) rec(j, 32'h2600_0000, 32'(j));
        load(300);
        start();
        run_to(T_FIRST + T_REC * 255 + 4);
        check("max_records", 64'(mprj_io[31:0]), 64'h0000_00FF);
        check("max_csb", 64'(flash_csb), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
